rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters:
  - the in-order pipeline writeback stage (port A);
  - a long-latency return path (port B), e.g. a load return after a cache miss.
- Holds a pending-write scoreboard, so decode can stall on registers whose long-latency write has not committed.
- Sits between the WB stage, the long-latency unit and the register file write port (we/waddr/wdata).

Parameters:
- FIFO_DEPTH, 2, entries in the port-B return buffer (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty B buffer may lose to A before A is stalled.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- wb_we  in  1  port A write request.
- wb_waddr  in  5  port A destination.
- wb_wdata  in  32  port A data.
- wb_stall  out  1  port A write not taken this cycle; WB must hold.
- lt_valid  in  1  port B return valid.
- lt_waddr  in  5  port B destination.
- lt_wdata  in  32  port B data.
- lt_ready  out  1  port B buffer can accept (not full).
- iss_valid  in  1  long-latency op issuing with a destination.
- iss_dest  in  5  its destination register.
- iss_ready  out  1  issue allowed (destination not already pending).
- q_addr1, q_addr2  in  5 each  decode source queries.
- q_busy1, q_busy2  out  1 each  queried register is pending.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  5  register file write address (registered).
- rf_wdata  out  32  register file write data (registered).

Behaviour:
- Reset (async, resetn=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - wb_stall=0, lt_ready=1, iss_ready=1, q_busy1=0, q_busy2=0;
  - buffer emptied, pending bitmap cleared, starve counter=0, FSM=IDLE.
  - Reset mid-operation drops all buffered returns; no partial writes.
- Write-port outputs are registered, one-cycle latency:
  - A: wb_we at cycle t with no stall → rf_we at t+1.
  - B: accepted at t (lt_valid&&lt_ready) → earliest rf_we at t+2 (buffered at t, head granted t+1).
- Address 0:
  - Any grant to r0 drives rf_we=0.
  - r0 is never marked pending; q_busy for address 0 is always 0; iss_ready is 1 for iss_dest=0.
- Buffer:
  - FIFO of {waddr, wdata}, pointers wrap modulo FIFO_DEPTH.
  - lt_ready = !full. Push while full is ignored.
  - Push and pop in the same cycle are allowed, including when full, in which case lt_ready=0 and the push is not taken.
- Grant FSM, evaluated every cycle on current state:
  - IDLE (buffer empty): A granted; wb_stall=0; counter=0. Go to WAIT when the buffer becomes non-empty.
  - WAIT (buffer non-empty):
    - If wb_we=0, or wb_waddr=0 (A's write is a no-op, so A is not starved), grant B head, pop, counter=0.
    - Else grant A, counter+1.
    - When counter reaches STARVE_LIMIT, go to FORCE.
    - Return to IDLE when the buffer becomes empty after a pop with no simultaneous push.
  - FORCE:
    - wb_stall = wb_we; B head granted and popped; counter=0.
    - Next state is WAIT if the buffer is still non-empty, else IDLE.
    - A is never stalled two consecutive cycles.
- Scoreboard (32-bit pending bitmap):
  - iss_ready = !pend[iss_dest] || iss_dest==0.
  - iss_valid&&iss_ready sets pend[iss_dest] at the posedge.
  - Clears at the posedge on which a registered B-sourced rf_we to that address is committed. The register file is written at the same edge.
  - q_busy reads the current bitmap; a register is still busy in its commit cycle and free the cycle after, when the file holds the new value.
  - Set and clear of the same bit in one cycle cannot occur (iss_ready=0 while pending).
  - Set and clear of different bits in one cycle both take effect.
- Ordering:
  - Decode must not let an A-path instruction write a register whose q_busy=1, so A and B never target the same pending register.
  - The arbiter does not reorder B returns (FIFO order).

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32;
  - wb_req struct {we, waddr, wdata};
  - FSM state enum {IDLE, WAIT, FORCE}.
- One natural sub-module: rf_wb_fifo, the parameterized sync FIFO with push/pop/full/empty and async active-low reset.
- FSM, scoreboard and output register stay in the top.

Test Plan:
- A only, no B: wb_we=1, waddr=5, wdata=0x1234 at t → rf_we=1, waddr=5, wdata=0x1234 at t+1; wb_stall stays 0.
- Idle A: iss r8; lt_valid with waddr=8, wdata=0xDEADBEEF at t, wb_we=0 → rf_we=1 to r8 at t+2; q_busy1(r8)=1 through t+2, 0 at t+3.
- Starvation:
  - B pending while wb_we=1 (nonzero waddr) every cycle → A granted STARVE_LIMIT=4 cycles, then wb_stall=1 for exactly one cycle and B is written.
  - A's held write lands the cycle after.
- Buffer full: 3 B returns back-to-back with A busy, depth 2 → lt_ready=0 on the third; no lost or duplicated writes; returns appear in order.
- Zero register:
  - iss_dest=0 → iss_ready=1 and no pending bit.
  - B return to r0 → rf_we stays 0.
  - Re-issue to a pending r9 → iss_ready=0 until r9 commits.
- Reset mid-operation: assert resetn=0 with 2 buffered entries and r3 pending → next cycle rf_we=0, lt_ready=1, q_busy(r3)=0, FSM=IDLE; no stale write after release.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared definitions for the register-file write-port arbiter:
//   REG_ADDR_W / DATA_W / NUM_REGS : register file geometry
//   RET_W                          : width of one buffered long-latency return
//   wb_req_t                       : one write request {we, waddr, wdata}
//   arb_state_t                    : grant FSM states
// ----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;
   localparam int RET_W      = REG_ADDR_W + DATA_W;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] waddr;
      logic [DATA_W-1:0]     wdata;
   } wb_req_t;

   // Explicit encodings keep the state values stable for anything that
   // probes the state register by value.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// ----------------------------------------------------------------------------
// rf_wb_fifo
// Small synchronous FIFO holding long-latency returns until they win the
// register file write port.
// Ports:
//   clk, rst_ni        clock, asynchronous active-low reset
//   push_i, wdata_i    enqueue request and its payload (ignored when full)
//   pop_i              dequeue request (ignored when empty)
//   rdata_o            current head entry
//   full_o, empty_o    occupancy flags
//   count_o            number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module rf_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   // A push while full is dropped even if a pop happens in the same cycle;
   // the producer sees not-ready and retries.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single write port between the in-order WB stage
// (port A) and a long-latency return path (port B), and tracks which
// registers still have a long-latency write outstanding.
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   wb_we/wb_waddr/wb_wdata         port A write request
//   wb_stall                        port A not taken this cycle, WB holds
//   lt_valid/lt_waddr/lt_wdata      port B return
//   lt_ready                        port B buffer not full
//   iss_valid/iss_dest              long-latency issue with destination
//   iss_ready                       destination not already pending
//   q_addr1/q_addr2, q_busy1/2      decode pending-register queries
//   rf_we/rf_waddr/rf_wdata         registered register file write port
// ----------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0]     wb_wdata,
   output logic                  wb_stall,
   input  logic                  lt_valid,
   input  logic [REG_ADDR_W-1:0] lt_waddr,
   input  logic [DATA_W-1:0]     lt_wdata,
   output logic                  lt_ready,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_dest,
   output logic                  iss_ready,
   input  logic [REG_ADDR_W-1:0] q_addr1,
   input  logic [REG_ADDR_W-1:0] q_addr2,
   output logic                  q_busy1,
   output logic                  q_busy2,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata
);

   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

   // Return buffer
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FCNT_W-1:0]     fifo_count;
   logic [RET_W-1:0]      fifo_head;
   logic                  push;
   logic                  pop;
   logic [REG_ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0]     head_data;

   // Arbitration
   arb_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   wb_req_t               grant;
   wb_req_t               b_req;
   logic                  grant_b;
   logic                  last_out;

   // Output register and scoreboard
   logic                  rf_we_q;
   logic [REG_ADDR_W-1:0] rf_waddr_q;
   logic [DATA_W-1:0]     rf_wdata_q;
   logic                  rf_from_b_q;
   logic [NUM_REGS-1:0]   pend_q, pend_d;

   assign lt_ready = !fifo_full;
   assign push     = lt_valid && !fifo_full;

   rf_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RET_W)
   ) u_fifo (
      .clk     (clk),
      .rst_ni  (resetn),
      .push_i  (push),
      .wdata_i ({lt_waddr, lt_wdata}),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign head_addr = fifo_head[RET_W-1 -: REG_ADDR_W];
   assign head_data = fifo_head[DATA_W-1:0];
   assign b_req     = '{we: !fifo_empty, waddr: head_addr, wdata: head_data};

   // The buffer drains to empty when its only entry leaves and nothing
   // arrives in the same cycle.
   assign last_out  = (fifo_count == FCNT_W'(1)) && !push;

   // A no-op A request (no write, or a write to r0) yields to B without
   // counting as a loss for B, so it never contributes to starvation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wb_stall = 1'b0;
      pop      = 1'b0;
      grant_b  = 1'b0;
      grant    = '{we: wb_we, waddr: wb_waddr, wdata: wb_wdata};
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (push) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!wb_we || (wb_waddr == '0)) begin
               grant   = b_req;
               grant_b = 1'b1;
               pop     = 1'b1;
               cnt_d   = '0;
               if (last_out) state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_d = ST_FORCE;
            end
         end
         ST_FORCE: begin
            wb_stall = wb_we;
            grant    = b_req;
            grant_b  = 1'b1;
            pop      = 1'b1;
            cnt_d    = '0;
            state_d  = last_out ? ST_IDLE : ST_WAIT;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The bit for a B write clears on the edge that commits it to the file,
   // so decode sees it busy during the commit cycle and free afterwards.
   // r0 is never marked because writes to it are discarded.
   always_comb begin
      pend_d = pend_q;
      if (rf_we_q && rf_from_b_q) pend_d[rf_waddr_q] = 1'b0;
      if (iss_valid && iss_ready && (iss_dest != '0)) pend_d[iss_dest] = 1'b1;
   end

   assign iss_ready = (iss_dest == '0) || !pend_q[iss_dest];
   assign q_busy1   = pend_q[q_addr1];
   assign q_busy2   = pend_q[q_addr2];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pend_q      <= '0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         rf_from_b_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         rf_we_q     <= grant.we && (grant.waddr != '0);
         rf_from_b_q <= grant_b;
         if (grant.we) begin
            rf_waddr_q <= grant.waddr;
            rf_wdata_q <= grant.wdata;
         end
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule
